// File: rtl/wb_bus_arbiter_if.sv
// wb_bus_arbiter_if
//   Bundles the per-master request side and the shared Wishbone slave side of
//   wb_bus_arbiter into one interface.
//
//   Master k occupies bits [k*ADDR_W +: ADDR_W] of m_adr_i and
//   [k*DATA_W +: DATA_W] of m_dat_i.
//
//   Modports:
//     slave  : the arbiter's view. It is the slave of the N requesters and drives
//              the shared slave bus.
//     master : the opposite view, used by whatever drives the requesters and the
//              slave's response.
//
//   Signals:
//     m_cyc_i/m_stb_i/m_we_i  per-master request, strobe and write enable
//     m_adr_i/m_dat_i         per-master address and write data (packed)
//     m_ack_o/m_err_o         ack and timeout error, routed to the owner only
//     m_dat_o                 read data, broadcast to all masters
//     s_cyc_o..s_dat_o        shared slave request
//     s_dat_i/s_ack_i         slave response
//     grant_o                 one-hot current owner, 0 when idle
interface wb_bus_arbiter_if #(
    parameter int unsigned NUM_MASTERS = 3,
    parameter int unsigned ADDR_W      = 20,
    parameter int unsigned DATA_W      = 8
);
    logic [NUM_MASTERS-1:0]        m_cyc_i;
    logic [NUM_MASTERS-1:0]        m_stb_i;
    logic [NUM_MASTERS-1:0]        m_we_i;
    logic [NUM_MASTERS*ADDR_W-1:0] m_adr_i;
    logic [NUM_MASTERS*DATA_W-1:0] m_dat_i;
    logic [NUM_MASTERS-1:0]        m_ack_o;
    logic [NUM_MASTERS-1:0]        m_err_o;
    logic [DATA_W-1:0]             m_dat_o;
    logic                          s_cyc_o;
    logic                          s_stb_o;
    logic                          s_we_o;
    logic [ADDR_W-1:0]             s_adr_o;
    logic [DATA_W-1:0]             s_dat_o;
    logic [DATA_W-1:0]             s_dat_i;
    logic                          s_ack_i;
    logic [NUM_MASTERS-1:0]        grant_o;

    modport slave (
        input  m_cyc_i, m_stb_i, m_we_i, m_adr_i, m_dat_i, s_dat_i, s_ack_i,
        output m_ack_o, m_err_o, m_dat_o,
               s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o, grant_o
    );

    modport master (
        output m_cyc_i, m_stb_i, m_we_i, m_adr_i, m_dat_i, s_dat_i, s_ack_i,
        input  m_ack_o, m_err_o, m_dat_o,
               s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o, grant_o
    );
endinterface

// File: rtl/wb_bus_arbiter.sv
// wb_bus_arbiter
//   Shares one Wishbone slave bus among NUM_MASTERS requesters (0 = video,
//   1 = CPU, 2 = SPI). Fixed priority with index 0 highest. A requester that has
//   waited STARVE_LIMIT cycles wins the next arbitration. The owner keeps the bus
//   for as long as it holds cyc. A strobe left unacknowledged for TIMEOUT_CYCLES
//   is terminated with a one-cycle err to the owner.
//
//   Ports:
//     clock_i    system clock
//     reset_n_i  synchronous reset, active low
//     bus        wb_bus_arbiter_if.slave (request side, slave side, grant_o)
module wb_bus_arbiter #(
    parameter int unsigned NUM_MASTERS    = 3,
    parameter int unsigned STARVE_LIMIT   = 64,
    parameter int unsigned TIMEOUT_CYCLES = 32
) (
    input logic             clock_i,
    input logic             reset_n_i,
    wb_bus_arbiter_if.slave bus
);
    localparam int unsigned ADDR_W = 20;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned WAIT_W = $clog2(STARVE_LIMIT + 1);
    localparam int unsigned TO_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(STARVE_LIMIT);
    localparam logic [TO_W-1:0]   TO_MAX   = TO_W'(TIMEOUT_CYCLES);

    typedef enum logic [0:0] {
        ST_IDLE,
        ST_BUSY
    } state_t;

    state_t                 state_q, state_d;
    logic [NUM_MASTERS-1:0] grant_q, grant_d;
    logic [WAIT_W-1:0]      wait_cnt_q [NUM_MASTERS];
    logic [WAIT_W-1:0]      wait_cnt_d [NUM_MASTERS];
    logic [TO_W-1:0]        to_cnt_q, to_cnt_d;
    logic                   to_flag_q, to_flag_d;

    logic                   owner_cyc, owner_stb, owner_we;
    logic [ADDR_W-1:0]      owner_adr;
    logic [DATA_W-1:0]      owner_dat;
    logic [NUM_MASTERS-1:0] starved, pick, winner;
    logic                   found;
    logic                   busy, to_fire;

    always_comb begin : owner_mux
        owner_cyc = 1'b0;
        owner_stb = 1'b0;
        owner_we  = 1'b0;
        owner_adr = '0;
        owner_dat = '0;
        for (int unsigned k = 0; k < NUM_MASTERS; k++) begin
            if (grant_q[k]) begin
                owner_cyc = bus.m_cyc_i[k];
                owner_stb = bus.m_stb_i[k];
                owner_we  = bus.m_we_i[k];
                owner_adr = bus.m_adr_i[k*ADDR_W +: ADDR_W];
                owner_dat = bus.m_dat_i[k*DATA_W +: DATA_W];
            end
        end
    end

    // Starved requesters form their own priority class; within a class the
    // lowest index wins.
    always_comb begin : winner_sel
        starved = '0;
        winner  = '0;
        found   = 1'b0;
        for (int unsigned k = 0; k < NUM_MASTERS; k++) begin
            starved[k] = bus.m_cyc_i[k] && (wait_cnt_q[k] >= WAIT_MAX);
        end
        pick = (|starved) ? starved : bus.m_cyc_i;
        for (int unsigned k = 0; k < NUM_MASTERS; k++) begin
            if (pick[k] && !found) begin
                winner[k] = 1'b1;
                found     = 1'b1;
            end
        end
    end

    always_comb begin : fsm_next
        state_d    = state_q;
        grant_d    = grant_q;
        wait_cnt_d = wait_cnt_q;
        to_cnt_d   = to_cnt_q;
        to_flag_d  = to_flag_q;
        busy       = (state_q == ST_BUSY);

        case (state_q)
            ST_IDLE: begin
                if (|bus.m_cyc_i) begin
                    state_d = ST_BUSY;
                    grant_d = winner;
                end
            end
            ST_BUSY: begin
                if (!owner_cyc) begin
                    state_d = ST_IDLE;
                    grant_d = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
            end
        endcase

        for (int unsigned k = 0; k < NUM_MASTERS; k++) begin
            if (!bus.m_cyc_i[k] || (!busy && winner[k])) begin
                wait_cnt_d[k] = '0;
            end else if (!(busy && grant_q[k]) && (wait_cnt_q[k] != WAIT_MAX)) begin
                wait_cnt_d[k] = wait_cnt_q[k] + WAIT_W'(1);
            end
        end

        // The counter parks at TO_MAX; to_flag_q makes err a single pulse and
        // masks the slave strobe until the owner withdraws stb. An ack in the
        // firing cycle takes precedence over err.
        to_fire = busy && owner_stb && !bus.s_ack_i && !to_flag_q && (to_cnt_q == TO_MAX);
        if (!busy || !owner_stb || bus.s_ack_i) begin
            to_cnt_d = '0;
        end else if (to_cnt_q != TO_MAX) begin
            to_cnt_d = to_cnt_q + TO_W'(1);
        end
        if (!busy || !owner_stb) begin
            to_flag_d = 1'b0;
        end else if (to_fire) begin
            to_flag_d = 1'b1;
        end

        bus.s_cyc_o = busy && owner_cyc;
        bus.s_stb_o = busy && owner_stb && !to_flag_q;
        bus.s_we_o  = busy && owner_we;
        bus.s_adr_o = busy ? owner_adr : '0;
        bus.s_dat_o = busy ? owner_dat : '0;
        bus.m_ack_o = (busy && bus.s_ack_i) ? grant_q : '0;
        bus.m_err_o = to_fire ? grant_q : '0;
        bus.m_dat_o = bus.s_dat_i;
        bus.grant_o = grant_q;
    end

    always_ff @(posedge clock_i) begin
        if (!reset_n_i) begin
            state_q    <= ST_IDLE;
            grant_q    <= '0;
            wait_cnt_q <= '{default: '0};
            to_cnt_q   <= '0;
            to_flag_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            wait_cnt_q <= wait_cnt_d;
            to_cnt_q   <= to_cnt_d;
            to_flag_q  <= to_flag_d;
        end
    end
endmodule

// File: tb/tb_wb_bus_arbiter.sv
// tb_wb_bus_arbiter
//   Self-checking bench for wb_bus_arbiter. Expected grants, acks and errors are
//   queued when stimulus is driven and compared by a negedge monitor when the DUT
//   produces them; timing-specific points are checked inline.
module tb_wb_bus_arbiter;
    localparam int unsigned N = 3;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    wb_bus_arbiter_if #(.NUM_MASTERS(N)) bus ();

    wb_bus_arbiter #(
        .NUM_MASTERS   (N),
        .STARVE_LIMIT  (64),
        .TIMEOUT_CYCLES(32)
    ) dut (
        .clock_i  (clk),
        .reset_n_i(rst_n),
        .bus      (bus.slave)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int cyc_n    = 0;
    int s0n;
    int c0n;
    logic done;

    logic [31:0] exp_grant_q[$];
    logic [31:0] exp_ack_q[$];      // {vec, data}: vec at [10:8], data at [7:0]
    logic [31:0] exp_err_q[$];
    logic [31:0] exp_err_cyc_q[$];
    logic [31:0] mon_e;
    logic [N-1:0] prev_grant = '0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc_n);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    task automatic wait_grant(input int unsigned idx, input string tag);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 8 && !ok; i++) begin
            tick();
            if (bus.grant_o[idx]) ok = 1'b1;
        end
        if (!ok) check_eq(tag, {29'd0, bus.grant_o}, 32'd1 << idx);
    endtask

    always @(posedge clk) cyc_n <= cyc_n + 1;

    always @(negedge clk) begin
        if (bus.grant_o != '0 && prev_grant == '0) begin
            check_eq("grant_onehot", {31'd0, $onehot(bus.grant_o)}, 32'd1);
            if (exp_grant_q.size() == 0) check_eq("grant_unexp", {29'd0, bus.grant_o}, 32'd0);
            else check_eq("grant", {29'd0, bus.grant_o}, exp_grant_q.pop_front());
        end
        prev_grant <= bus.grant_o;
        if (bus.m_ack_o != '0) begin
            if (exp_ack_q.size() == 0) check_eq("ack_unexp", {29'd0, bus.m_ack_o}, 32'd0);
            else begin
                mon_e = exp_ack_q.pop_front();
                check_eq("ack_vec", {29'd0, bus.m_ack_o}, {29'd0, mon_e[10:8]});
                check_eq("ack_dat", {24'd0, bus.m_dat_o}, {24'd0, mon_e[7:0]});
            end
        end
        if (bus.m_err_o != '0) begin
            if (exp_err_q.size() == 0) check_eq("err_unexp", {29'd0, bus.m_err_o}, 32'd0);
            else begin
                check_eq("err_vec", {29'd0, bus.m_err_o}, exp_err_q.pop_front());
                check_eq("err_cyc", cyc_n, exp_err_cyc_q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, n_checks %0d", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n         = 1'b0;
        bus.m_cyc_i   = '1;
        bus.m_stb_i   = '0;
        bus.m_we_i    = '0;
        bus.m_adr_i   = '0;
        bus.m_dat_i   = '0;
        bus.s_ack_i   = 1'b1;
        bus.s_dat_i   = '0;

        // Reset held with every master requesting and the slave acking.
        repeat (3) begin
            tick();
            at_neg();
            check_eq("rst_grant", {29'd0, bus.grant_o}, 32'd0);
            check_eq("rst_scyc", {31'd0, bus.s_cyc_o}, 32'd0);
            check_eq("rst_ack", {29'd0, bus.m_ack_o}, 32'd0);
        end
        tick();
        rst_n       = 1'b1;
        bus.m_cyc_i = '0;
        bus.s_ack_i = 1'b0;
        tick();

        // Priority: all three raise together.
        bus.m_cyc_i = 3'b111;
        exp_grant_q.push_back(32'h1);
        tick();
        at_neg();
        check_eq("lat_grant", {29'd0, bus.grant_o}, 32'h1);
        check_eq("lat_scyc", {31'd0, bus.s_cyc_o}, 32'd1);
        tick();
        bus.m_cyc_i[0] = 1'b0;
        exp_grant_q.push_back(32'h2);
        at_neg();
        check_eq("rel_scyc", {31'd0, bus.s_cyc_o}, 32'd0);
        tick();
        at_neg();
        check_eq("idle_gap", {29'd0, bus.grant_o}, 32'd0);
        tick();

        // Read by master 1, slave acks on the third cycle of the strobe.
        bus.m_stb_i[1]       = 1'b1;
        bus.m_we_i[1]        = 1'b0;
        bus.m_adr_i[20 +: 20] = 20'h08000;
        at_neg();
        check_eq("rd_stb", {31'd0, bus.s_stb_o}, 32'd1);
        check_eq("rd_adr", {12'd0, bus.s_adr_o}, 32'h08000);
        check_eq("rd_we", {31'd0, bus.s_we_o}, 32'd0);
        tick();
        tick();
        bus.s_ack_i = 1'b1;
        bus.s_dat_i = 8'hA5;
        exp_ack_q.push_back(32'h2A5);
        tick();
        bus.s_ack_i    = 1'b0;
        bus.s_dat_i    = 8'h00;
        bus.m_stb_i[1] = 1'b0;
        bus.m_cyc_i[1] = 1'b0;
        exp_grant_q.push_back(32'h4);
        wait_grant(2, "grant_m2");

        // Write by master 2; the slave never acks.
        bus.m_stb_i[2]        = 1'b1;
        bus.m_we_i[2]         = 1'b1;
        bus.m_adr_i[40 +: 20] = 20'h50003;
        bus.m_dat_i[16 +: 8]  = 8'h3C;
        c0n = cyc_n;
        exp_err_q.push_back(32'h4);
        exp_err_cyc_q.push_back(c0n + 32);
        at_neg();
        check_eq("wr_we", {31'd0, bus.s_we_o}, 32'd1);
        check_eq("wr_adr", {12'd0, bus.s_adr_o}, 32'h50003);
        check_eq("wr_dat", {24'd0, bus.s_dat_o}, 32'h3C);
        repeat (33) tick();
        at_neg();
        check_eq("to_stb_low", {31'd0, bus.s_stb_o}, 32'd0);
        check_eq("to_scyc_held", {31'd0, bus.s_cyc_o}, 32'd1);
        check_eq("to_grant_held", {29'd0, bus.grant_o}, 32'h4);
        tick();
        bus.m_stb_i[2] = 1'b0;
        bus.m_we_i[2]  = 1'b0;
        tick();

        // Ack lands in the very cycle the timeout would fire.
        bus.m_stb_i[2] = 1'b1;
        repeat (32) tick();
        bus.s_ack_i = 1'b1;
        bus.s_dat_i = 8'h5A;
        exp_ack_q.push_back(32'h45A);
        at_neg();
        check_eq("coll_no_err", {29'd0, bus.m_err_o}, 32'd0);
        tick();
        bus.s_ack_i    = 1'b0;
        bus.s_dat_i    = 8'h00;
        bus.m_stb_i[2] = 1'b0;
        bus.m_cyc_i[2] = 1'b0;
        tick();
        tick();

        // Starvation: master 0 re-requests with 10-cycle tenures, master 2 waits.
        bus.m_cyc_i[0] = 1'b1;
        bus.m_cyc_i[2] = 1'b1;
        s0n = cyc_n;
        exp_grant_q.push_back(32'h1);
        done = 1'b0;
        for (int it = 0; it < 12 && !done; it++) begin
            wait_grant(0, "starve_m0");
            repeat (9) tick();
            tick();
            bus.m_cyc_i[0] = 1'b0;
            tick();
            bus.m_cyc_i[0] = 1'b1;
            if (cyc_n - s0n >= 64) begin
                exp_grant_q.push_back(32'h4);
                done = 1'b1;
            end else begin
                exp_grant_q.push_back(32'h1);
            end
        end
        wait_grant(2, "starve_m2");
        check_eq("starve_cyc", cyc_n - s0n, 32'd73);
        bus.m_cyc_i[2] = 1'b0;
        exp_grant_q.push_back(32'h1);
        wait_grant(0, "after_starve_m0");
        bus.m_cyc_i[0] = 1'b0;
        tick();
        tick();

        // Reset in the middle of a tenure.
        bus.m_cyc_i[1] = 1'b1;
        exp_grant_q.push_back(32'h2);
        tick();
        bus.m_stb_i[1] = 1'b1;
        tick();
        rst_n = 1'b0;
        tick();
        bus.s_ack_i = 1'b1;
        at_neg();
        check_eq("mrst_grant", {29'd0, bus.grant_o}, 32'd0);
        check_eq("mrst_scyc", {31'd0, bus.s_cyc_o}, 32'd0);
        check_eq("mrst_sstb", {31'd0, bus.s_stb_o}, 32'd0);
        check_eq("mrst_sadr", {12'd0, bus.s_adr_o}, 32'd0);
        check_eq("mrst_ack", {29'd0, bus.m_ack_o}, 32'd0);
        check_eq("mrst_err", {29'd0, bus.m_err_o}, 32'd0);
        tick();
        bus.m_cyc_i = '0;
        bus.m_stb_i = '0;
        bus.s_ack_i = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        tick();

        check_eq("sb_grant_left", exp_grant_q.size(), 32'd0);
        check_eq("sb_ack_left", exp_ack_q.size(), 32'd0);
        check_eq("sb_err_left", exp_err_q.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
